// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants and register-view grid geometry.
// All constants are 10 bits wide so they compare directly against hcnt/vcnt.
package vga_pkg;

    localparam logic [9:0] H_VIS     = 10'd640;
    localparam logic [9:0] H_FP      = 10'd16;
    localparam logic [9:0] H_SYNC    = 10'd96;
    localparam logic [9:0] H_TOTAL   = 10'd800;
    localparam logic [9:0] V_VIS     = 10'd480;
    localparam logic [9:0] V_FP      = 10'd10;
    localparam logic [9:0] V_SYNC    = 10'd2;
    localparam logic [9:0] V_TOTAL   = 10'd525;

    localparam logic [9:0] GRID_X0   = 10'd64;
    localparam logic [9:0] GRID_Y0   = 10'd112;
    localparam logic [9:0] CELL      = 10'd32;
    localparam logic [9:0] GRID_COLS = 10'd16;
    localparam logic [9:0] GRID_ROWS = 10'd8;

    localparam logic [9:0] GRID_X1   = GRID_X0 + GRID_COLS * CELL;
    localparam logic [9:0] GRID_Y1   = GRID_Y0 + GRID_ROWS * CELL;
    localparam logic [9:0] HS_START  = H_VIS + H_FP;
    localparam logic [9:0] HS_END    = HS_START + H_SYNC;
    localparam logic [9:0] VS_START  = V_VIS + V_FP;
    localparam logic [9:0] VS_END    = VS_START + V_SYNC;

    localparam logic [1:0] LVL_OFF   = 2'b00;
    localparam logic [1:0] LVL_DIM   = 2'b01;
    localparam logic [1:0] LVL_FULL  = 2'b11;

    // Field order gives the VGA bus layout {HS, VS, R[1:0], G[1:0], B}.
    typedef struct packed {
        logic       hs_n;
        logic       vs_n;
        logic [1:0] r;
        logic [1:0] g;
        logic       b;
    } vga_pix_t;

    localparam vga_pix_t PIX_IDLE = '{hs_n: 1'b1, vs_n: 1'b1, r: LVL_OFF, g: LVL_OFF, b: 1'b0};

    // Offset within a 32-px cell lies on the 2-px border band.
    function automatic logic cell_edge(input logic [4:0] off);
        return (off < 5'd2) || (off > 5'd29);
    endfunction

endpackage

// File: rtl/vga_timing.sv
// Pixel prescaler, 800x525 raster counters and raw (unregistered) sync levels.
// P_VCNT_RST is the line loaded on reset; it stays 0 in any real build.
module vga_timing
    import vga_pkg::*;
#(
    parameter logic [9:0] P_VCNT_RST = 10'd0
) (
    input  logic       CLK,
    input  logic       RST,
    output logic [9:0] o_hcnt,
    output logic [9:0] o_vcnt,
    output logic       o_pen,
    output logic       o_visible,
    output logic       o_hs_n,
    output logic       o_vs_n,
    output logic       o_frame_end
);

    logic [1:0] r_pre;
    logic [9:0] r_hcnt;
    logic [9:0] r_vcnt;
    logic       w_pen;
    logic       w_h_last;
    logic       w_v_last;

    assign w_pen    = (r_pre == 2'd3);
    assign w_h_last = (r_hcnt == H_TOTAL - 10'd1);
    assign w_v_last = (r_vcnt == V_TOTAL - 10'd1);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pre  <= 2'd0;
            r_hcnt <= 10'd0;
            r_vcnt <= P_VCNT_RST;
        end else begin
            r_pre <= r_pre + 2'd1;
            if (w_pen) begin
                if (w_h_last) begin
                    r_hcnt <= 10'd0;
                    r_vcnt <= w_v_last ? 10'd0 : r_vcnt + 10'd1;
                end else begin
                    r_hcnt <= r_hcnt + 10'd1;
                end
            end
        end
    end

    assign o_hcnt      = r_hcnt;
    assign o_vcnt      = r_vcnt;
    assign o_pen       = w_pen;
    assign o_visible   = (r_hcnt < H_VIS) && (r_vcnt < V_VIS);
    assign o_hs_n      = !((r_hcnt >= HS_START) && (r_hcnt < HS_END));
    assign o_vs_n      = !((r_vcnt >= VS_START) && (r_vcnt < VS_END));
    // High for the single CLK whose pen wraps both counters to 0.
    assign o_frame_end = w_pen && w_h_last && w_v_last;

endmodule

// File: rtl/vga_regview.sv
// Live VGA view of an 8x16-bit register file: one 32x32 cell per bit,
// green for 1, dim red for 0, MSB leftmost, one register per grid row.
module vga_regview
    import vga_pkg::*;
#(
    parameter logic [9:0] P_VCNT_RST = 10'd0
) (
    input  logic        CLK,
    input  logic        RST,
    output logic [2:0]  dbg_addr,
    input  logic [15:0] dbg_data,
    output logic [6:0]  VGA,
    output logic        frame_start
);

    logic [9:0] w_hcnt;
    logic [9:0] w_vcnt;
    logic       w_pen;
    logic       w_visible;
    logic       w_hs_n;
    logic       w_vs_n;
    logic       w_frame_end;

    vga_timing #(
        .P_VCNT_RST (P_VCNT_RST)
    ) u_timing (
        .CLK         (CLK),
        .RST         (RST),
        .o_hcnt      (w_hcnt),
        .o_vcnt      (w_vcnt),
        .o_pen       (w_pen),
        .o_visible   (w_visible),
        .o_hs_n      (w_hs_n),
        .o_vs_n      (w_vs_n),
        .o_frame_end (w_frame_end)
    );

    logic       w_in_x;
    logic       w_in_y;
    logic [8:0] w_dx;
    logic [7:0] w_dy;
    logic [3:0] w_col;
    logic       w_bit;
    logic       w_border;
    vga_pix_t   w_pix;
    vga_pix_t   r_vga;

    assign w_in_x = (w_hcnt >= GRID_X0) && (w_hcnt < GRID_X1);
    assign w_in_y = (w_vcnt >= GRID_Y0) && (w_vcnt < GRID_Y1);

    // Grid-relative offsets; only meaningful while inside the grid.
    assign w_dx = 9'(w_hcnt - GRID_X0);
    assign w_dy = 8'(w_vcnt - GRID_Y0);

    assign dbg_addr = w_in_y ? w_dy[7:5] : 3'd0;

    assign w_col    = w_dx[8:5];
    assign w_bit    = dbg_data[4'd15 - w_col];
    assign w_border = cell_edge(w_dx[4:0]) || cell_edge(w_dy[4:0]);

    always_comb begin
        w_pix      = PIX_IDLE;
        w_pix.hs_n = w_hs_n;
        w_pix.vs_n = w_vs_n;
        if (w_visible && w_in_x && w_in_y && !w_border) begin
            if (w_bit) begin
                w_pix.g = LVL_FULL;
            end else begin
                w_pix.r = LVL_DIM;
            end
        end
    end

    // Sync and colour share one register so both lag the counters by one pixel.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_vga <= PIX_IDLE;
        end else if (w_pen) begin
            r_vga <= w_pix;
        end
    end

    assign VGA         = r_vga;
    assign frame_start = w_frame_end;

endmodule

// File: tb/tb_vga_regview.sv
// Bench for vga_regview: several instances start on different raster lines so
// the grid, sync pulses and frame wrap are all reached in a short run.
`timescale 1ns/1ps
module tb_vga_regview;

    localparam int N = 6;
    localparam logic [N-1:0][9:0] INIT =
        {10'd505, 10'd480, 10'd355, 10'd120, 10'd98, 10'd0};

    localparam int NPX = 10;
    localparam int LPX_H [NPX] = '{80, 112, 560, 64, 80, 80, 700, 300, 80, 80};
    localparam int LPX_V [NPX] = '{128, 128, 128, 128, 368, 100, 5, 490, 112, 116};
    localparam logic [6:0] LPX_VAL [NPX] = '{7'b1100110, 7'b1101000, 7'b1100110, 7'b1100000,
                                             7'b1100000, 7'b1100000, 7'b0100000, 7'b1000000,
                                             7'b1100000, 7'b1100110};
    localparam int NAD = 5;
    localparam int LAD_V [NAD]   = '{112, 367, 368, 100, 128};
    localparam int LAD_VAL [NAD] = '{0, 7, 0, 0, 0};

    logic                  CLK = 1'b0;
    logic [N-1:0]          rst;
    logic [N-1:0][2:0]     dbg_addr;
    logic [N-1:0][15:0]    dbg_data;
    logic [N-1:0][6:0]     vga;
    logic [N-1:0]          frame_start;
    logic [15:0]           regs [8];

    always #5 CLK = ~CLK;

    for (genvar g = 0; g < N; g++) begin : g_dut
        vga_regview #(
            .P_VCNT_RST (INIT[g])
        ) dut (
            .CLK         (CLK),
            .RST         (rst[g]),
            .dbg_addr    (dbg_addr[g]),
            .dbg_data    (dbg_data[g]),
            .VGA         (vga[g]),
            .frame_start (frame_start[g])
        );
        assign dbg_data[g] = regs[dbg_addr[g]];
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0h, expected %0h at %0t", name, idx, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int pos_h(input int k);
        return (k / 4) % 800;
    endfunction

    function automatic int pos_v(input int i, input int k);
        return (int'(INIT[i]) + (k / 4) / 800) % 525;
    endfunction

    function automatic int row_addr(input int v);
        return (v >= 112 && v < 368) ? (v - 112) / 32 : 0;
    endfunction

    function automatic logic [6:0] pixel(input int h, input int v, input logic [15:0] data);
        logic       hs_n, vs_n;
        logic [1:0] r, g;
        int         dx, dy;
        hs_n = !(h >= 656 && h <= 751);
        vs_n = !(v >= 490 && v <= 491);
        r = 2'b00;
        g = 2'b00;
        dx = h - 64;
        dy = v - 112;
        if (h < 640 && v < 480 && dx >= 0 && dx < 512 && dy >= 0 && dy < 256 &&
            dx % 32 >= 2 && dx % 32 <= 29 && dy % 32 >= 2 && dy % 32 <= 29) begin
            if (data[15 - dx / 32]) g = 2'b11;
            else                    r = 2'b01;
        end
        return {hs_n, vs_n, r, g, 1'b0};
    endfunction

    // k = CLK edges seen since reset released; pen is every 4th edge.
    int         k       [N];
    bit         valid   [N];
    bit         exp_has [N];
    int         exp_h   [N];
    int         exp_v   [N];
    logic [6:0] exp_vga [N];

    always @(posedge CLK) begin
        for (int i = 0; i < N; i++) begin
            if (rst[i]) begin
                k[i]       <= 0;
                valid[i]   <= 1'b1;
                exp_has[i] <= 1'b0;
                exp_vga[i] <= 7'b1100000;
            end else if (valid[i]) begin
                if (k[i] % 4 == 3) begin
                    exp_vga[i] <= pixel(pos_h(k[i]), pos_v(i, k[i]), regs[row_addr(pos_v(i, k[i]))]);
                    exp_h[i]   <= pos_h(k[i]);
                    exp_v[i]   <= pos_v(i, k[i]);
                    exp_has[i] <= 1'b1;
                end
                k[i] <= k[i] + 1;
            end
        end
    end

    int px_hit [NPX];
    int ad_hit [NAD];
    int cur_h, cur_v;

    always @(negedge CLK) begin
        for (int i = 0; i < N; i++) begin
            if (valid[i]) begin
                cur_h = pos_h(k[i]);
                cur_v = pos_v(i, k[i]);
                check("vga", i, 32'(vga[i]), 32'(exp_vga[i]));
                check("frame_start", i, 32'(frame_start[i]),
                      (k[i] % 4 == 3 && cur_h == 799 && cur_v == 524) ? 1 : 0);
                check("dbg_addr", i, 32'(dbg_addr[i]), row_addr(cur_v));
                if (exp_has[i]) begin
                    for (int j = 0; j < NPX; j++) begin
                        if (exp_h[i] == LPX_H[j] && exp_v[i] == LPX_V[j]) begin
                            px_hit[j]++;
                            check("pixel_literal", j, 32'(vga[i]), 32'(LPX_VAL[j]));
                        end
                    end
                end
                for (int j = 0; j < NAD; j++) begin
                    if (cur_v == LAD_V[j]) begin
                        ad_hit[j]++;
                        check("addr_literal", j, 32'(dbg_addr[i]), LAD_VAL[j]);
                    end
                end
            end
        end
    end

    // Register contents move at random mid-pixel times; row 0 stays 16'h8001.
    initial begin
        regs[0] = 16'h8001;
        for (int r = 1; r < 8; r++) regs[r] = 16'($urandom);
        forever begin
            @(posedge CLK);
            #($urandom_range(1, 3));
            if ($urandom_range(0, 3) == 0) regs[1 + $urandom_range(0, 6)] = 16'($urandom);
        end
    end

    // ---------------- directed sequences ----------------
    initial begin
        for (int j = 0; j < NPX; j++) px_hit[j] = 0;
        for (int j = 0; j < NAD; j++) ad_hit[j] = 0;
        rst = '1;
        repeat (3) @(negedge CLK);
        check("reset_vga", 0, 32'(vga[0]), 32'h60);
        check("reset_frame_start", 0, 32'(frame_start[0]), 0);
        check("reset_dbg_addr", 0, 32'(dbg_addr[0]), 0);
        rst = '0;

        fork
            begin : br_line
                int n, f1, f2, low, t;
                n = 0;
                while (n < 4000 && vga[0][6] !== 1'b0) begin @(negedge CLK); n++; end
                f1 = n;
                check("hs_first_fall_clks", 0, f1, 2628);
                low = 0;
                while (low < 1000 && vga[0][6] === 1'b0) begin @(negedge CLK); n++; low++; end
                check("hs_low_clks", 0, low, 384);
                while (n < f1 + 4000 && vga[0][6] !== 1'b0) begin @(negedge CLK); n++; end
                f2 = n;
                check("line_period_clks", 0, f2 - f1, 3200);
                t = 0;
                while (t < 40000 && !(pos_h(k[0]) == 400 && pos_v(0, k[0]) == 10)) begin
                    @(negedge CLK);
                    t++;
                end
                check("mid_reset_reached", 0, (t < 40000) ? 1 : 0, 1);
                rst[0] = 1'b1;
                repeat (3) @(negedge CLK);
                check("mid_reset_vga", 0, 32'(vga[0]), 32'h60);
                check("mid_reset_frame_start", 0, 32'(frame_start[0]), 0);
                check("mid_reset_dbg_addr", 0, 32'(dbg_addr[0]), 0);
                rst[0] = 1'b0;
                n = 0;
                while (n < 4000 && vga[0][6] !== 1'b0) begin @(negedge CLK); n++; end
                check("hs_fall_after_mid_reset", 0, n, 2628);
            end
            begin : br_vsync
                int n, low;
                n = 0;
                while (n < 40000 && vga[4][5] !== 1'b0) begin @(negedge CLK); n++; end
                check("vs_first_fall_clks", 4, n, 32004);
                low = 0;
                while (low < 10000 && vga[4][5] === 1'b0) begin @(negedge CLK); low++; end
                check("vs_low_clks", 4, low, 6400);
            end
            begin : br_frame
                int n, cnt, first;
                cnt = 0;
                first = -1;
                for (n = 1; n <= 70000; n++) begin
                    @(negedge CLK);
                    if (frame_start[5] === 1'b1) begin
                        cnt++;
                        if (first < 0) first = n;
                    end
                end
                check("frame_start_count", 5, cnt, 1);
                check("frame_start_clk", 5, first, 63999);
            end
        join

        for (int j = 0; j < NPX; j++) check("pixel_literal_reached", j, (px_hit[j] > 0) ? 1 : 0, 1);
        for (int j = 0; j < NAD; j++) check("addr_literal_reached", j, (ad_hit[j] > 0) ? 1 : 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_regview.md
VGA_REGVIEW -- requirements
Module: vga_regview

Interface
REQ-001 SHALL have port CLK  input  1  100 MHz system clock; all logic on rising edge.
REQ-002 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port dbg_addr  output  3  register-file debug read address (row being drawn).
REQ-004 SHALL have port dbg_data  input  16  register contents for dbg_addr, combinational from source, same cycle.
REQ-005 SHALL have port VGA  output  7  {HS, VS, R[1:0], G[1:0], B}: bit6=HS, bit5=VS, bits4:3=R, bits2:1=G, bit0=B.
REQ-006 SHALL have port frame_start  output  1  one-CLK pulse when vcnt and hcnt both wrap to 0.

Function
REQ-007 SHALL divide CLK by 4 with 2-bit prescaler; pixel enable (pen) asserted when prescaler == 3 (25 MHz pixel rate).
REQ-008 SHALL keep hcnt 0..799, advancing only on pen; wraps 799 -> 0.
REQ-009 SHALL keep vcnt 0..524, advancing on pen when hcnt == 799; wraps 524 -> 0; simultaneous hcnt/vcnt wrap in one pen.
REQ-010 SHALL mark visible area as hcnt < 640 and vcnt < 480.
REQ-011 SHALL make HS active-low for hcnt 656..751 inclusive; VS active-low for vcnt 490..491 inclusive.
REQ-012 SHALL define grid: x 64..575 (16 cells), y 112..367 (8 rows), cells 32x32 px.
REQ-013 SHALL drive dbg_addr = (vcnt-112)[7:5] inside grid rows, else 3'd0.
REQ-014 SHALL map column c = (hcnt-64)[8:5] to dbg_data bit (15-c); MSB leftmost.
REQ-015 SHALL blank a 2-px cell border: pixels with (hcnt-64)[4:0] or (vcnt-112)[4:0] in {0,1,30,31} are black.
REQ-016 SHALL colour cell interior: bit=1 -> G=2'b11, R=0, B=0; bit=0 -> R=2'b01, G=0, B=0.
REQ-017 SHALL drive all colour bits 0 outside grid and outside visible area.
REQ-018 SHALL register HS, VS, colour on pen; VGA reflects the counter values of the previous pen, same 1-pixel latency for sync and colour.
REQ-019 SHALL hold VGA unchanged between pens.
REQ-020 SHALL pulse frame_start for exactly the one CLK whose pen causes hcnt 799->0 and vcnt 524->0.
REQ-021 SHALL sample dbg_data only on pen cycles; dbg_data changes mid-pixel have no effect until next pen.
REQ-022 SHALL run independently of pipeline PAUSE/STEP; display always live.

Reset
REQ-023 SHALL on RST clear prescaler, hcnt, vcnt to 0.
REQ-024 SHALL on RST drive VGA = 7'b1100000 (syncs inactive high, colour black), frame_start = 0.
REQ-025 SHALL, on RST asserted mid-frame, restart at hcnt=0, vcnt=0; first pen 4 CLKs after RST deasserts.

Structure
REQ-026 SHALL place timing constants (H_VIS 640, H_FP 16, H_SYNC 96, H_TOTAL 800, V_VIS 480, V_FP 10, V_SYNC 2, V_TOTAL 525, GRID_X0 64, GRID_Y0 112, CELL 32) in a shared package vga_pkg.
REQ-027 SHALL split counters/prescaler/sync into sub-module vga_timing (outputs hcnt, vcnt, pen, visible, hs_n, vs_n); vga_regview holds grid decode and output registers.

Verification
REQ-028 SHALL test reset: RST high 3 CLKs -> VGA == 7'b1100000, frame_start 0; first pen at 4th CLK after release.
REQ-029 SHALL test line timing: free-run one line -> HS low exactly 96 pens, line period 3200 CLKs.
REQ-030 SHALL test frame timing: free-run -> VS low 2 lines, frame_start period 1,680,000 CLKs.
REQ-031 SHALL test pixels: dbg_data=16'h8001 for row 0 -> pixel (x=80,y=128) green 2'b11, (x=112,y=128) R=2'b01, (x=560,y=128) green, (x=64,y=128) black border.
REQ-032 SHALL test addressing: at y=112 dbg_addr=0, y=367 dbg_addr=7, y=368 and y=100 dbg_addr=0 with colour black.
REQ-033 SHALL test mid-frame reset: RST at hcnt=400, vcnt=200 -> counters 0, VGA 7'b1100000, normal timing resumes.
